// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
// Holds the FSM state type, default geometry and a clog2 that never returns 0.
package seq_adder_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   localparam int unsigned DefWidth = 16;
   localparam int unsigned DefChunk = 4;

   // Counter width for n items; a single item still needs one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_adder_slice.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
// One instance is reused by seq_adder for every chunk.
module seq_adder_slice #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         ci_i,
   output logic [W-1:0] s_o,
   output logic         co_o
);

   logic c;

   always_comb begin
      c   = ci_i;
      s_o = '0;
      for (int unsigned i = 0; i < W; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ c;
         c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      co_o = c;
   end

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock through a shared slice adder,
// with a start/busy/done handshake and carry-out / signed-overflow flags.
module seq_adder
   import seq_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CHUNK = DefChunk
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned KW     = clog2_min1(NCHUNK);

   if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_geometry
      $error("seq_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CHUNK-1:0] slice_a, slice_b, slice_s;
   logic             slice_co;

   // Operand mux kept apart from the next-state logic so the slice sits outside that block.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int unsigned i = 0; i < NCHUNK; i++) begin
         if (k_q == KW'(i)) begin
            slice_a = a_q[i*CHUNK +: CHUNK];
            slice_b = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   seq_adder_slice #(
      .W (CHUNK)
   ) u_slice (
      .a_i  (slice_a),
      .b_i  (slice_b),
      .ci_i (carry_q),
      .s_o  (slice_s),
      .co_o (slice_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      k_d     = k_q;
      carry_d = carry_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : ci;
               s_d     = '0;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            for (int unsigned i = 0; i < NCHUNK; i++) begin
               if (k_q == KW'(i)) s_d[i*CHUNK +: CHUNK] = slice_s;
            end
            carry_d = slice_co;
            if (k_q == KW'(NCHUNK - 1)) begin
               co_d    = slice_co;
               // Operands of equal sign whose sum flips sign.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[CHUNK-1] != a_q[WIDTH-1]);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               k_d     = '0;
               state_d = StIdle;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;

endmodule
